// File: rtl/fixed_to_float_pkg.sv
// Shared float format helpers: field positions, bias and width derivation
// for the {sign, exponent, mantissa} packed format used by the float blocks.
package fixed_to_float_pkg;

    localparam int DEFAULT_MANTISSA_SIZE = 23;
    localparam int DEFAULT_EXPONENT_SIZE = 8;

    // Total packed width: sign + exponent + stored mantissa.
    function automatic int float_size(input int mantissa_size, input int exponent_size);
        return 1 + exponent_size + mantissa_size;
    endfunction

    // Exponent bias 2^(E-1) - 1.
    function automatic int float_bias(input int exponent_size);
        return (1 << (exponent_size - 1)) - 1;
    endfunction

    // Bit index of the sign within the packed word.
    function automatic int sign_pos(input int mantissa_size, input int exponent_size);
        return mantissa_size + exponent_size;
    endfunction

    // Lowest bit index of the exponent field.
    function automatic int exp_lsb(input int mantissa_size);
        return mantissa_size;
    endfunction

    // Width of a leading-one position for a given data width (at least 1).
    function automatic int lod_pos_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fixed_to_float_leading_one_detect.sv
// Combinational leading-one detector: position of the highest set bit plus
// a flag for an all-zero input.
module leading_one_detect
    import fixed_to_float_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int POS_W = lod_pos_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Scan upward so the highest set bit is the last one recorded.
    always_comb begin
        pos  = '0;
        zero = ~|data;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                pos = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/fixed_to_float.sv
// Three-stage pipelined signed fixed-point to packed float converter.
// Stage 1 unpacks sign/magnitude, stage 2 finds the leading one, stage 3
// normalises, rounds half-up and packs. All registers hold while ce is low.
module fixed_to_float
    import fixed_to_float_pkg::*;
#(
    parameter int MANTISSA_SIZE = DEFAULT_MANTISSA_SIZE,
    parameter int EXPONENT_SIZE = DEFAULT_EXPONENT_SIZE,
    parameter int INT_SIZE      = 32,
    parameter int FRACTION_SIZE = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ce,
    input  logic [INT_SIZE-1:0]                  intIn,
    input  logic                                 validIn,
    output logic [MANTISSA_SIZE+EXPONENT_SIZE:0] floatOut,
    output logic                                 validOut
);

    localparam int FLOAT_SIZE = float_size(MANTISSA_SIZE, EXPONENT_SIZE);
    localparam int BIAS       = float_bias(EXPONENT_SIZE);
    localparam int POS_W      = lod_pos_width(INT_SIZE);
    localparam int NORM_W     = MANTISSA_SIZE + 2;

    if ((BIAS - FRACTION_SIZE < 1) ||
        (BIAS + INT_SIZE - 1 - FRACTION_SIZE >= (1 << EXPONENT_SIZE) - 1)) begin : g_range_check
        $error("fixed_to_float: exponent range cannot hold every input without denormal/infinity");
    end

    logic                  sign1_q, sign1_d;
    logic [INT_SIZE-1:0]   mag1_q, mag1_d;
    logic                  valid1_q, valid1_d;

    logic                  sign2_q, sign2_d;
    logic [INT_SIZE-1:0]   mag2_q, mag2_d;
    logic [POS_W-1:0]      pos2_q, pos2_d;
    logic                  zero2_q, zero2_d;
    logic                  valid2_q, valid2_d;

    logic [FLOAT_SIZE-1:0] float_q, float_d;
    logic                  valid3_q, valid3_d;

    logic [POS_W-1:0]      lod_pos;
    logic                  lod_zero;

    // Stage 1: sign and magnitude; the most negative input maps to 2^(INT_SIZE-1).
    always_comb begin
        sign1_d  = sign1_q;
        mag1_d   = mag1_q;
        valid1_d = valid1_q;
        if (ce) begin
            sign1_d  = intIn[INT_SIZE-1];
            mag1_d   = intIn[INT_SIZE-1] ? (INT_SIZE'(0) - intIn) : intIn;
            valid1_d = validIn;
        end
    end

    leading_one_detect #(
        .WIDTH (INT_SIZE),
        .POS_W (POS_W)
    ) u_lod (
        .data (mag1_q),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    // Stage 2: capture leading-one position and zero flag alongside the data.
    always_comb begin
        sign2_d  = sign2_q;
        mag2_d   = mag2_q;
        pos2_d   = pos2_q;
        zero2_d  = zero2_q;
        valid2_d = valid2_q;
        if (ce) begin
            sign2_d  = sign1_q;
            mag2_d   = mag1_q;
            pos2_d   = lod_pos;
            zero2_d  = lod_zero;
            valid2_d = valid1_q;
        end
    end

    logic [NORM_W-1:0]        norm;
    logic [MANTISSA_SIZE:0]   round_sum;
    logic                     round_carry;
    logic [EXPONENT_SIZE-1:0] exp_res;
    int                       p;
    int                       exp_i;

    // Stage 3: both shift directions place the hidden one at bit NORM_W-1 with
    // the round bit at bit 0, so a single half-up add serves both cases; carry
    // out of the stored mantissa means the hidden one overflowed.
    always_comb begin
        p = int'(pos2_q);
        if (p <= MANTISSA_SIZE) begin
            norm = NORM_W'(mag2_q) << (MANTISSA_SIZE + 1 - p);
        end else begin
            norm = NORM_W'(mag2_q >> (p - MANTISSA_SIZE - 1));
        end
        round_sum   = {1'b0, norm[MANTISSA_SIZE:1]} + (MANTISSA_SIZE+1)'(norm[0]);
        round_carry = round_sum[MANTISSA_SIZE];
        exp_i = BIAS - FRACTION_SIZE + p;
        if (round_carry) begin
            exp_i = exp_i + 1;
        end
        exp_res = EXPONENT_SIZE'(exp_i);

        float_d  = float_q;
        valid3_d = valid3_q;
        if (ce) begin
            valid3_d = valid2_q;
            if (zero2_q || !norm[NORM_W-1]) begin
                float_d = '0;
            end else begin
                float_d = {sign2_q, exp_res, round_sum[MANTISSA_SIZE-1:0]};
            end
        end
    end

    // Pipeline registers; reset clears everything regardless of ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign1_q  <= 1'b0;
            mag1_q   <= '0;
            valid1_q <= 1'b0;
            sign2_q  <= 1'b0;
            mag2_q   <= '0;
            pos2_q   <= '0;
            zero2_q  <= 1'b1;
            valid2_q <= 1'b0;
            float_q  <= '0;
            valid3_q <= 1'b0;
        end else begin
            sign1_q  <= sign1_d;
            mag1_q   <= mag1_d;
            valid1_q <= valid1_d;
            sign2_q  <= sign2_d;
            mag2_q   <= mag2_d;
            pos2_q   <= pos2_d;
            zero2_q  <= zero2_d;
            valid2_q <= valid2_d;
            float_q  <= float_d;
            valid3_q <= valid3_d;
        end
    end

    assign floatOut = float_q;
    assign validOut = valid3_q;

endmodule

// File: doc/fixed_to_float.md
# fixed_to_float

Pipelined converter from signed two's-complement fixed-point to IEEE-754-style packed float. It sits directly upstream of the float adder and produces operands in the same `{sign, exponent, mantissa}` format with the same `MANTISSA_SIZE`/`EXPONENT_SIZE` parameterisation. It accepts one conversion per enabled clock and shares the adder's `ce` stall convention, so both blocks can be driven from one enable.

## Interface
- `MANTISSA_SIZE`, 23: stored mantissa bits (hidden one not stored).
- `EXPONENT_SIZE`, 8: exponent bits; bias = 2^(EXPONENT_SIZE-1) - 1.
- `INT_SIZE`, 32: input width, signed two's complement.
- `FRACTION_SIZE`, 0: binary point position; input value = `intIn` / 2^FRACTION_SIZE.
- Constraint: bias - FRACTION_SIZE >= 1 and bias + INT_SIZE - 1 - FRACTION_SIZE < 2^EXPONENT_SIZE - 1. No denormal or infinity output is ever required; elaboration fails otherwise.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ce`, in, 1: clock enable; all pipeline registers hold when low.
- `intIn`, in, INT_SIZE: fixed-point operand.
- `validIn`, in, 1: `intIn` is meaningful this cycle.
- `floatOut`, out, 1+EXPONENT_SIZE+MANTISSA_SIZE: packed result.
- `validOut`, out, 1: `floatOut` corresponds to a sampled `validIn`.

## Operation
- Stage 1 (Unpack): sign = MSB of `intIn`; magnitude = |`intIn`| as INT_SIZE-bit unsigned. The most negative input gives magnitude 2^(INT_SIZE-1), which must be representable without overflow.
- Stage 2 (Detect): leading-one position `p` of the magnitude, plus a zero flag; magnitude, sign and valid are forwarded.
- Stage 3 (Normalise/Round/Pack):
  - If zero: output all-zero (+0.0), including for sign. Negative zero is never produced.
  - Exponent = bias + `p` - FRACTION_SIZE.
  - If `p` <= MANTISSA_SIZE: left-shift so the hidden one lands at bit MANTISSA_SIZE. Exact, no rounding.
  - Else: right-shift by `p` - MANTISSA_SIZE, then round half-up by adding the most significant discarded bit.
  - If rounding carries past the hidden one: exponent + 1, mantissa = 0.
- Valid propagates through a 3-deep shift register alongside the data. Data registers are updated regardless of valid; only `validOut` qualifies the output.

## Timing
- Latency: 3 `ce`-qualified rising edges from sampling `intIn`/`validIn` to `floatOut`/`validOut`.
- Throughput: one conversion per enabled clock; no backpressure.
- `ce` low: every register, including the valid chain and outputs, holds its value. Outputs stay stable for as long as `ce` stays low.
- `reset` high at an edge:
  - All valid bits clear and `floatOut` becomes 0, independent of `ce`.
  - In-flight conversions are discarded.
  - `validOut` is 0 at the first edge after reset deasserts, and stays 0 until 3 enabled edges after the first post-reset `validIn`.
- `reset` and `ce` both high at the same edge: reset wins.

## Structure
- A shared float package holds the format constants: sign/exponent/mantissa positions, bias, and the `FLOAT_SIZE` derivation. The adder uses the same constants.
- One sub-module: `leading_one_detect`. It is combinational, parameterised on input width, and outputs `$clog2`-sized position plus a zero flag. It is instantiated in stage 2.

## Test plan
All scenarios use defaults unless stated.
- Basic values (1, -1, 0 with `validIn`=1) -> `floatOut` = 0x3F800000, 0xBF800000, 0x00000000 on the third enabled edge; `validOut`=1 on each.
- 16777217 (2^24+1) -> 0x4B800001 (round half-up). 0x7FFFFFFF -> 0x4F000000 (carry increments exponent). -2147483648 -> 0xCF000000.
- Fixed point with FRACTION_SIZE=16: 0x00018000 -> 0x3FC00000 (1.5). 0xFFFF0000 -> 0xBF800000.
- Back-to-back stream of 100 random ints, with `ce` randomly deasserted ~30% of cycles -> outputs match the reference model in order. Outputs stay frozen on `ce`-low cycles. Valid bubbles are preserved.
- `reset` pulsed with 3 conversions in flight and `ce`=0 -> next cycle `validOut`=0 and `floatOut`=0. No stale result appears afterwards.
